// File: rtl/vga_timing_receiver_if.sv
// Sync inputs and measured-timing / pixel-coordinate outputs of the VGA timing receiver.
// The sync source drives through master; the receiver attaches as slave.
interface vga_timing_receiver_if #(
    parameter int CNT_W = 11
);
    logic             hsync;
    logic             vsync;
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync_w;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync_w;
    logic             locked;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             valid;
    logic             frame_start;
    logic             err;

    modport master (
        output hsync, vsync,
        input  h_total, h_sync_w, v_total, v_sync_w,
        input  locked, pix_x, pix_y, valid, frame_start, err
    );

    modport slave (
        input  hsync, vsync,
        output h_total, h_sync_w, v_total, v_sync_w,
        output locked, pix_x, pix_y, valid, frame_start, err
    );
endinterface

// File: rtl/vga_timing_receiver.sv
// Measures incoming VGA sync timing, locks after repeated identical frames and then
// regenerates pixel coordinates, a data-valid strobe and frame-start pulses.
module vga_timing_receiver #(
    parameter int CNT_W       = 11,
    parameter bit SYNC_POL    = 1'b0,
    parameter int H_START     = 184,
    parameter int V_START     = 29,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int LOCK_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    vga_timing_receiver_if.slave vga
);
    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_START + V_ACTIVE);
    localparam logic DEASSERT = ~SYNC_POL;

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    match_q, match_d;
    logic             latch, err_d;

    logic             hs_q, hs_qq, vs_q, vs_qq;
    logic [CNT_W-1:0] h_pos_q, v_line_q, frame_lines_q;
    logic             vpend_q;
    logic [CNT_W-1:0] hs_run_q, cur_hsw_q, vs_run_q, cur_vsw_q, cur_ht_q;
    logic             have_prev_q, have_ht_q, ht_bad_q;

    logic [CNT_W-1:0] h_total_q, h_sync_w_q, v_total_q, v_sync_w_q;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    logic             valid_q, fs_q, err_q;

    logic             hs_a, hs_pa, vs_a, vs_pa, hedge, vedge, hs_fall, vs_fall;
    logic [CNT_W-1:0] h_len, fr_ht, fr_lines;
    logic             mismatch_h, fr_bad, frame_eq, timeout, valid_d;

    assign hs_a    = (hs_q == SYNC_POL);
    assign hs_pa   = (hs_qq == SYNC_POL);
    assign vs_a    = (vs_q == SYNC_POL);
    assign vs_pa   = (vs_qq == SYNC_POL);
    assign hedge   = hs_a & ~hs_pa;
    assign vedge   = vs_a & ~vs_pa;
    assign hs_fall = ~hs_a & hs_pa;
    assign vs_fall = ~vs_a & vs_pa;

    // The hedge coincident with a vedge still closes a line of the ending frame.
    assign h_len      = h_pos_q + CNT_ONE;
    assign mismatch_h = hedge & have_ht_q & (h_len != cur_ht_q);
    assign fr_ht      = (hedge & have_prev_q) ? h_len : cur_ht_q;
    assign fr_lines   = frame_lines_q + CNT_W'(hedge);
    assign fr_bad     = ht_bad_q | mismatch_h;
    assign frame_eq   = !fr_bad && (fr_ht == h_total_q) && (fr_lines == v_total_q) &&
                        (cur_hsw_q == h_sync_w_q) && (cur_vsw_q == v_sync_w_q);
    assign timeout    = ~hedge & (h_pos_q == CNT_MAX - CNT_ONE);

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        latch   = 1'b0;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = SEARCH;
            match_d = '0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                SEARCH: if (vedge) state_d = MEASURE;
                MEASURE: if (vedge) begin
                    latch   = 1'b1;
                    match_d = '0;
                    state_d = VERIFY;
                end
                VERIFY: if (vedge) begin
                    if (frame_eq) begin
                        match_d = match_q + MW'(1);
                        if (match_q + MW'(1) >= MW'(LOCK_FRAMES)) state_d = LOCKED;
                    end else begin
                        latch   = 1'b1;
                        match_d = '0;
                        err_d   = 1'b1;
                    end
                end
                LOCKED: if ((hedge && (h_len != h_total_q)) ||
                            (vedge && (fr_lines != v_total_q))) begin
                    err_d   = 1'b1;
                    state_d = MEASURE;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    assign valid_d = (state_d == LOCKED) && (h_pos_q >= H_LO) && (h_pos_q < H_HI) &&
                     (v_line_q >= V_LO) && (v_line_q < V_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= DEASSERT;  hs_qq <= DEASSERT;
            vs_q <= DEASSERT;  vs_qq <= DEASSERT;
            h_pos_q <= '0;     v_line_q <= '0;   frame_lines_q <= '0;  vpend_q <= 1'b0;
            hs_run_q <= '0;    cur_hsw_q <= '0;  vs_run_q <= '0;       cur_vsw_q <= '0;
            cur_ht_q <= '0;    have_prev_q <= 1'b0; have_ht_q <= 1'b0; ht_bad_q <= 1'b0;
        end else begin
            hs_q  <= vga.hsync;
            hs_qq <= hs_q;
            vs_q  <= vga.vsync;
            vs_qq <= vs_q;

            if (hedge)                   h_pos_q <= '0;
            else if (h_pos_q != CNT_MAX) h_pos_q <= h_len;

            if (hedge) begin
                v_line_q <= (vpend_q | vedge) ? '0 :
                            (v_line_q == CNT_MAX) ? v_line_q : v_line_q + CNT_ONE;
                vpend_q  <= 1'b0;
            end else if (vedge) begin
                vpend_q  <= 1'b1;
            end

            if (vedge)      frame_lines_q <= '0;
            else if (hedge) frame_lines_q <= fr_lines;

            if (hedge)                          hs_run_q <= CNT_ONE;
            else if (hs_a && hs_run_q != CNT_MAX) hs_run_q <= hs_run_q + CNT_ONE;
            if (hs_fall) cur_hsw_q <= hs_run_q;

            if (vedge)              vs_run_q <= CNT_W'(hedge);
            else if (vs_a && hedge) vs_run_q <= vs_run_q + CNT_ONE;
            if (vs_fall) cur_vsw_q <= vs_run_q;

            // A line length is only trusted once two hedges bracket it.
            if (timeout) begin
                have_prev_q <= 1'b0;
                have_ht_q   <= 1'b0;
            end else if (hedge) begin
                have_prev_q <= 1'b1;
                if (have_prev_q) begin
                    cur_ht_q  <= h_len;
                    have_ht_q <= 1'b1;
                end
            end

            ht_bad_q <= vedge ? 1'b0 : fr_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;  match_q <= '0;     err_q <= 1'b0;     fs_q <= 1'b0;
            h_total_q <= '0;    h_sync_w_q <= '0;  v_total_q <= '0;   v_sync_w_q <= '0;
            valid_q <= 1'b0;    pix_x_q <= '0;     pix_y_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            err_q   <= err_d;
            fs_q    <= vedge && (state_d == LOCKED);
            if (latch) begin
                h_total_q  <= fr_ht;
                v_total_q  <= fr_lines;
                h_sync_w_q <= cur_hsw_q;
                v_sync_w_q <= cur_vsw_q;
            end
            valid_q <= valid_d;
            pix_x_q <= valid_d ? h_pos_q - H_LO : '0;
            pix_y_q <= valid_d ? v_line_q - V_LO : '0;
        end
    end

    assign vga.h_total     = h_total_q;
    assign vga.h_sync_w    = h_sync_w_q;
    assign vga.v_total     = v_total_q;
    assign vga.v_sync_w    = v_sync_w_q;
    assign vga.locked      = (state_q == LOCKED);
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.valid       = valid_q;
    assign vga.frame_start = fs_q;
    assign vga.err         = err_q;
endmodule
